program_counter_stack: RTL

Parametrised next-generation program counter for the MIPS-style fetch path. It keeps the existing controls: instruction step, byte step, absolute jump and branch. It adds signed branch offsets, a hold (stall) input, and subroutine call/return backed by a circular return-address stack. Sticky overflow and underflow error flags are provided. It sits between the control FSM and the instruction/byte memory address bus.

---
 rtl/program_counter_stack.sv | 108 ++++++++++
 1 files changed

// File: rtl/program_counter_stack.sv
// Fetch-path program counter: step/byte-step/jump/branch plus call/return via a circular return stack.
// One-cycle registered update; hold freezes all state and no command is ever queued.
module program_counter_stack #(
  parameter int ADDR_W      = 8,
  parameter int BSEL_W      = 2,
  parameter int OFFSET_W    = 6,
  parameter int STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             hold,
  input  logic                             update_msbs,
  input  logic                             update_lsbs,
  input  logic                             jump,
  input  logic                             call,
  input  logic                             ret,
  input  logic                             brancher,
  input  logic [ADDR_W-BSEL_W-1:0]         jump_destination,
  input  logic [OFFSET_W-1:0]              branch_offset,
  input  logic                             err_clr,
  output logic [ADDR_W-1:0]                mem_addr,
  output logic [$clog2(STACK_DEPTH):0]     stack_count,
  output logic                             stack_overflow,
  output logic                             stack_underflow
);

  localparam int IDX_W = ADDR_W - BSEL_W;
  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(STACK_DEPTH);

  logic [IDX_W-1:0]  r_idx;
  logic [BSEL_W-1:0] r_bsel;
  logic [PTR_W-1:0]  r_wptr;
  logic [CNT_W-1:0]  r_count;
  logic              r_ovf;
  logic              r_unf;
  logic [IDX_W-1:0]  r_stack [STACK_DEPTH];

  logic [IDX_W-1:0]  w_idx_inc;
  logic [IDX_W-1:0]  w_offset;
  logic [IDX_W-1:0]  w_top;
  logic              w_higher;
  logic              w_push;
  logic              w_pop_req;
  logic              w_full;
  logic              w_empty;

  assign w_idx_inc = r_idx + IDX_W'(1);
  assign w_offset  = IDX_W'($signed(branch_offset));
  assign w_top     = r_stack[r_wptr - PTR_W'(1)];
  assign w_full    = (r_count == FULL_CNT);
  assign w_empty   = (r_count == '0);
  // Anything above call in priority masks both stack operations.
  assign w_higher  = hold | update_msbs | update_lsbs | jump;
  assign w_push    = ~w_higher & call;
  assign w_pop_req = ~w_higher & ~call & ret;

  // Entries hold only the instruction index; returns always land on byte 0.
  always_ff @(posedge clk) begin
    if (w_push) r_stack[r_wptr] <= w_idx_inc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx   <= '0;
      r_bsel  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (!hold) begin
      if (update_msbs) begin
        r_idx  <= w_idx_inc;
        r_bsel <= '0;
      end else if (update_lsbs) begin
        r_bsel <= r_bsel + BSEL_W'(1);
      end else if (jump) begin
        r_idx  <= jump_destination;
        r_bsel <= '0;
      end else if (call) begin
        r_idx  <= jump_destination;
        r_bsel <= '0;
        r_wptr <= r_wptr + PTR_W'(1);
        if (!w_full) r_count <= r_count + CNT_W'(1);
      end else if (ret) begin
        if (!w_empty) begin
          r_idx   <= w_top;
          r_bsel  <= '0;
          r_wptr  <= r_wptr - PTR_W'(1);
          r_count <= r_count - CNT_W'(1);
        end
      end else if (brancher) begin
        r_idx  <= r_idx + w_offset;
        r_bsel <= '0;
      end
      // A new error in the same cycle beats the clear.
      r_ovf <= (r_ovf & ~err_clr) | (w_push & w_full);
      r_unf <= (r_unf & ~err_clr) | (w_pop_req & w_empty);
    end
  end

  assign mem_addr        = {r_idx, r_bsel};
  assign stack_count     = r_count;
  assign stack_overflow  = r_ovf;
  assign stack_underflow = r_unf;

endmodule
